axi_pipe_register: RTL and testbench

AXI_PIPE_REGISTER -- requirements
Module: axi_pipe_register

---
 rtl/axi_reg_pkg.sv | 16 +
 rtl/axi_pipe_stage.sv | 102 ++++++++++
 rtl/axi_pipe_register.sv | 79 +++++++
 tb/tb_axi_pipe_register.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_reg_pkg.sv
// Stage type encodings and per-stage capacity shared by the AXI pipe register and its testbench.
package axi_reg_pkg;

  localparam int REG_BYPASS = 0;
  localparam int REG_SIMPLE = 1;
  localparam int REG_SKID   = 2;

  function automatic int stage_capacity(input int reg_type);
    case (reg_type)
      REG_SIMPLE: return 1;
      REG_SKID:   return 2;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/axi_pipe_stage.sv
// One registered stage (simple: 1 beat, 1 beat/2 cycles; skid: 2 beats, 1 beat/cycle); latency 1 cycle.
// Backpressure: in_rdy_o is a register, so out_rdy_i never reaches it combinationally; flush empties the stage.
module axi_pipe_stage
  import axi_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_TYPE   = REG_SKID
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] in_dat_i,
  input  logic                  in_vld_i,
  output logic                  in_rdy_o,
  output logic [DATA_WIDTH-1:0] out_dat_o,
  output logic                  out_vld_o,
  input  logic                  out_rdy_i
);

  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_dat_q, out_dat_d;
  logic                  rdy_q, rdy_d;
  logic                  in_fire;

  assign in_fire   = in_vld_i & rdy_q;
  assign in_rdy_o  = rdy_q;
  assign out_vld_o = out_vld_q;
  assign out_dat_o = out_dat_q;

  generate
    if (REG_TYPE == REG_SIMPLE) begin : g_simple
      always_comb begin
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        if (in_fire) begin
          out_vld_d = 1'b1;
          out_dat_d = in_dat_i;
        end else if (out_rdy_i) begin
          out_vld_d = 1'b0;
        end
        if (flush_i) out_vld_d = 1'b0;
        rdy_d = ~out_vld_d;
      end
    end else begin : g_skid
      logic                  skid_vld_q, skid_vld_d;
      logic [DATA_WIDTH-1:0] skid_dat_q, skid_dat_d;

      // Ready tracks "skid empty", so a held skid beat implies no input this cycle.
      always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (skid_vld_q) begin
          if (out_rdy_i) begin
            out_dat_d  = skid_dat_q;
            skid_vld_d = 1'b0;
          end
        end else if (in_fire) begin
          if (!out_vld_q || out_rdy_i) begin
            out_vld_d = 1'b1;
            out_dat_d = in_dat_i;
          end else begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat_i;
          end
        end else if (out_rdy_i) begin
          out_vld_d = 1'b0;
        end
        if (flush_i) begin
          out_vld_d  = 1'b0;
          skid_vld_d = 1'b0;
        end
        rdy_d = ~skid_vld_d;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) skid_vld_q <= 1'b0;
        else        skid_vld_q <= skid_vld_d;
      end

      always_ff @(posedge clk) begin
        skid_dat_q <= skid_dat_d;
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      out_vld_q <= out_vld_d;
      rdy_q     <= rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    out_dat_q <= out_dat_d;
  end

endmodule

// File: rtl/axi_pipe_register.sv
// Cascade of STAGES identical register stages with occupancy count; latency STAGES cycles, wires when bypassed.
// Backpressure: s_ready comes from the first stage's register; flush forces it low and empties every stage.
module axi_pipe_register
  import axi_reg_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 2,
  parameter int REG_TYPE   = REG_SKID,
  parameter int CNT_WIDTH  = $clog2(2*STAGES+2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  count
);

  generate
    if (STAGES == 0 || REG_TYPE == REG_BYPASS) begin : g_bypass
      assign m_data  = s_data;
      assign m_valid = s_valid;
      assign s_ready = m_ready;
      assign count   = '0;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] dat [STAGES+1];
      logic                  vld [STAGES+1];
      logic                  rdy [STAGES+1];
      logic                  s_fire, m_fire;
      logic [CNT_WIDTH-1:0]  count_q, count_d;

      assign dat[0]      = s_data;
      assign vld[0]      = s_valid;
      assign rdy[STAGES] = m_ready;
      assign s_ready     = rdy[0] & ~flush;
      assign m_data      = dat[STAGES];
      assign m_valid     = vld[STAGES];
      assign count       = count_q;

      for (genvar i = 0; i < STAGES; i++) begin : g_stage
        axi_pipe_stage #(
          .DATA_WIDTH (DATA_WIDTH),
          .REG_TYPE   (REG_TYPE)
        ) u_stage (
          .clk       (clk),
          .rst_n     (rst_n),
          .flush_i   (flush),
          .in_dat_i  (dat[i]),
          .in_vld_i  (vld[i]),
          .in_rdy_o  (rdy[i]),
          .out_dat_o (dat[i+1]),
          .out_vld_o (vld[i+1]),
          .out_rdy_i (rdy[i+1])
        );
      end

      assign s_fire = s_valid & s_ready;
      assign m_fire = m_valid & m_ready;

      // A delivery coinciding with flush still completes; the count simply lands on zero.
      always_comb begin
        count_d = count_q;
        if (flush)                count_d = '0;
        else if (s_fire && !m_fire) count_d = count_q + CNT_WIDTH'(1);
        else if (m_fire && !s_fire) count_d = count_q - CNT_WIDTH'(1);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
      end
    end
  endgenerate

endmodule

// File: tb/tb_axi_pipe_register.sv
// Drives all STAGES 0..4 x REG_TYPE 0..2 variants; directed sequences plus a randomized scoreboard run.
module tb_axi_pipe_register;
  import axi_reg_pkg::*;

  localparam int NI = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sv [NI];
  logic       sr [NI];
  logic       mv [NI];
  logic       mr [NI];
  logic       fl [NI];
  logic [7:0] sd [NI];
  logic [7:0] md [NI];
  logic [3:0] cnt [NI];

  always #5 clk = ~clk;

  for (genvar gs = 0; gs < 5; gs++) begin : g_s
    for (genvar gt = 0; gt < 3; gt++) begin : g_t
      localparam int K = gs * 3 + gt;
      axi_pipe_register #(
        .DATA_WIDTH (8),
        .STAGES     (gs),
        .REG_TYPE   (gt),
        .CNT_WIDTH  (4)
      ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (sd[K]),
        .s_valid (sv[K]),
        .s_ready (sr[K]),
        .m_data  (md[K]),
        .m_valid (mv[K]),
        .m_ready (mr[K]),
        .flush   (fl[K]),
        .count   (cnt[K])
      );
    end
  end

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       fl;
    logic       e_mv;
    logic [7:0] e_md;
    logic       e_sr;
    int         e_cnt;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic       s_hit, m_hit;
  vec_t       tbl [12];
  int         nxt, n_acc, n_out, first_acc, first_mv, first_out, last_out, steady_bad;
  int         consec, max_cnt, mv_seen;
  logic       prev_acc;
  logic [7:0] rq [NI][16];
  int         rh [NI], rt [NI], dep [NI], beats [NI];
  logic       hold [NI];
  logic [7:0] hold_md [NI];
  logic       pend [NI];
  logic       sf, mf, all_done;
  int         rc;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock of instance k: scoreboard push on accept, pop-and-compare on delivery.
  task automatic step(input int k);
    logic [7:0] e;
    #1;
    s_hit = sv[k] && sr[k];
    m_hit = mv[k] && mr[k];
    if (s_hit) exp_q.push_back(sd[k]);
    if (m_hit) begin
      if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("beat_data", int'(md[k]), int'(e));
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    sv[k] = 1'b0;
    mr[k] = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      step(k);
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_count", int'(cnt[k]), 0);
    mr[k] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      sv[k] = 1'b0; mr[k] = 1'b0; fl[k] = 1'b0; sd[k] = 8'h00;
    end
    tbl[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0};
    tbl[1]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b1, 1};
    tbl[2]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA1, 1'b0, 2};
    tbl[3]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0, 2};
    tbl[4]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b1, 1};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b1, 1};
    tbl[6]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1};
    tbl[7]  = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0};
    tbl[9]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 0};

    // Reset state and first-edge ready.
    repeat (2) @(negedge clk);
    chk("rst_m_valid", int'(mv[8]), 0);
    chk("rst_s_ready", int'(sr[8]), 0);
    chk("rst_count", int'(cnt[8]), 0);
    rst_n = 1'b1;
    #1;
    chk("s_ready_before_edge", int'(sr[8]), 0);
    @(posedge clk);
    #1;
    chk("s_ready_first_edge", int'(sr[8]), 1);
    @(negedge clk);

    // Single skid stage: fill, skid, drain, multi-cycle flush.
    for (int i = 0; i < 12; i++) begin
      sv[5] = tbl[i].sv; sd[5] = tbl[i].sd; mr[5] = tbl[i].mr; fl[5] = tbl[i].fl;
      #1;
      chk($sformatf("tbl%0d_m_valid", i), int'(mv[5]), int'(tbl[i].e_mv));
      if (tbl[i].e_mv) chk($sformatf("tbl%0d_m_data", i), int'(md[5]), int'(tbl[i].e_md));
      chk($sformatf("tbl%0d_s_ready", i), int'(sr[5]), int'(tbl[i].e_sr));
      chk($sformatf("tbl%0d_count", i), int'(cnt[5]), tbl[i].e_cnt);
      @(negedge clk);
    end
    sv[5] = 1'b0; mr[5] = 1'b0; fl[5] = 1'b0;

    // Three skid stages streaming 0x01..0x10 with m_ready high.
    exp_q.delete();
    mr[11] = 1'b1; nxt = 1; first_acc = -1; first_mv = -1; first_out = -1; last_out = -1;
    n_out = 0; steady_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (mv[11] && first_mv < 0) first_mv = c;
      if (first_acc >= 0 && c >= first_acc + 3 && c <= first_acc + 15 && cnt[11] != 4'd3)
        steady_bad++;
      sv[11] = (nxt <= 16);
      sd[11] = 8'(nxt);
      step(11);
      if (s_hit) begin
        if (first_acc < 0) first_acc = c;
        nxt++;
      end
      if (m_hit) begin
        if (first_out < 0) first_out = c;
        last_out = c;
        n_out++;
      end
    end
    chk("stream_latency", first_mv - first_acc, 3);
    chk("stream_beats", n_out, 16);
    chk("stream_rate", last_out - first_out, 15);
    chk("stream_steady_count", steady_bad, 0);
    drain(11);

    // Two skid stages with m_ready low absorb exactly four beats.
    exp_q.delete();
    mr[8] = 1'b0; nxt = 8'h40; n_acc = 0;
    for (int c = 0; c < 12; c++) begin
      sv[8] = 1'b1;
      sd[8] = 8'(nxt);
      step(8);
      if (s_hit) begin n_acc++; nxt++; end
    end
    sv[8] = 1'b0;
    chk("fill_accepts", n_acc, 4);
    chk("fill_s_ready", int'(sr[8]), 0);
    chk("fill_count", int'(cnt[8]), 4);
    mr[8] = 1'b1; n_out = 0;
    for (int c = 0; c < 8; c++) begin
      step(8);
      if (m_hit) n_out++;
    end
    chk("fill_drained", n_out, 4);
    chk("fill_s_ready_after", int'(sr[8]), 1);
    chk("fill_count_after", int'(cnt[8]), 0);
    mr[8] = 1'b0;

    // Two simple stages accept one beat every other cycle.
    exp_q.delete();
    mr[7] = 1'b1; nxt = 8'h80; n_acc = 0; consec = 0; max_cnt = 0; prev_acc = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (int'(cnt[7]) > max_cnt) max_cnt = int'(cnt[7]);
      sv[7] = 1'b1;
      sd[7] = 8'(nxt);
      step(7);
      if (s_hit && prev_acc) consec++;
      prev_acc = s_hit;
      if (s_hit) begin n_acc++; nxt++; end
    end
    chk("simple_accepts", n_acc, 10);
    chk("simple_back_to_back", consec, 0);
    chk("simple_max_count_le2", int'(max_cnt <= 2), 1);
    drain(7);

    // Flush with three beats held: oldest delivered, rest discarded.
    exp_q.delete();
    mr[8] = 1'b0; nxt = 8'hC0; n_acc = 0;
    for (int c = 0; c < 10 && n_acc < 3; c++) begin
      sv[8] = 1'b1;
      sd[8] = 8'(nxt);
      step(8);
      if (s_hit) begin n_acc++; nxt++; end
    end
    sv[8] = 1'b0;
    chk("flush_pre_count", int'(cnt[8]), 3);
    fl[8] = 1'b1; mr[8] = 1'b1; sv[8] = 1'b1; sd[8] = 8'hEE;
    step(8);
    chk("flush_blocks_accept", int'(s_hit), 0);
    chk("flush_delivers_oldest", int'(m_hit), 1);
    exp_q.delete();
    chk("flush_count", int'(cnt[8]), 0);
    fl[8] = 1'b0; sv[8] = 1'b0;
    #1;
    chk("flush_s_ready_after", int'(sr[8]), 1);
    mv_seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (mv[8]) mv_seen++;
      step(8);
    end
    chk("flush_no_m_valid", mv_seen, 0);
    mr[8] = 1'b0;

    // Asynchronous reset with three beats held.
    exp_q.delete();
    mr[11] = 1'b0; n_acc = 0;
    for (int c = 0; c < 10 && n_acc < 3; c++) begin
      sv[11] = 1'b1;
      sd[11] = 8'(8'h50 + n_acc);
      step(11);
      if (s_hit) n_acc++;
    end
    sv[11] = 1'b0;
    chk("rst_mid_pre_count", int'(cnt[11]), 3);
    chk("rst_mid_pre_m_valid", int'(mv[11]), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_m_valid", int'(mv[11]), 0);
    chk("rst_mid_s_ready", int'(sr[11]), 0);
    chk("rst_mid_count", int'(cnt[11]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mr[11] = 1'b1;
    #1;
    chk("rst_rel_s_ready_pre", int'(sr[11]), 0);
    @(posedge clk);
    #1;
    chk("rst_rel_s_ready", int'(sr[11]), 1);
    chk("rst_rel_m_valid", int'(mv[11]), 0);
    @(negedge clk);
    mr[11] = 1'b0;
    exp_q.delete();

    // Random valid/ready on every variant, one ring-buffer scoreboard each.
    for (int k = 0; k < NI; k++) begin
      rh[k] = 0; rt[k] = 0; dep[k] = 0; beats[k] = 0;
      hold[k] = 1'b0; pend[k] = 1'b0; sd[k] = 8'($urandom);
    end
    all_done = 1'b0;
    rc = 0;
    while (!all_done && rc < 60000 && bad < 100) begin
      for (int k = 0; k < NI; k++) begin
        if (hold[k]) begin
          chk("rnd_hold_valid", int'(mv[k]), 1);
          chk("rnd_hold_data", int'(md[k]), int'(hold_md[k]));
        end
        sv[k] = 1'($urandom_range(0, 1));
        mr[k] = 1'($urandom_range(0, 1));
      end
      #1;
      for (int k = 0; k < NI; k++) begin
        sf = sv[k] && sr[k];
        mf = mv[k] && mr[k];
        if (sf) begin
          rq[k][rt[k]] = sd[k];
          rt[k] = (rt[k] + 1) % 16;
          dep[k]++;
        end
        if (mf) begin
          if (dep[k] == 0) chk($sformatf("rnd_underflow_%0d", k), 1, 0);
          else begin
            chk($sformatf("rnd_data_%0d", k), int'(md[k]), int'(rq[k][rh[k]]));
            rh[k] = (rh[k] + 1) % 16;
            dep[k]--;
            beats[k]++;
          end
        end
        hold[k]    = mv[k] && !mr[k] && (k / 3 > 0) && (k % 3 > 0);
        hold_md[k] = md[k];
        pend[k]    = sf;
      end
      @(negedge clk);
      all_done = 1'b1;
      for (int k = 0; k < NI; k++) begin
        if (pend[k]) sd[k] = 8'($urandom);
        chk($sformatf("rnd_count_%0d", k), int'(cnt[k]), dep[k]);
        chk($sformatf("rnd_count_bound_%0d", k),
            int'(int'(cnt[k]) <= (k / 3) * stage_capacity(k % 3)), 1);
        if (beats[k] < 10000) all_done = 1'b0;
      end
      rc++;
    end
    chk("rnd_all_beats_done", int'(all_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
